// File: rtl/bootram_pkg.sv
// Shared types and constants for the PicoRV32 boot RAM controller slice.
package bootram_pkg;

    localparam int BOOTRAM_LANES  = 4;
    localparam int BOOTRAM_ADDR_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RDATA = 2'd1,
        ST_ACK   = 2'd2
    } bootram_state_e;

endpackage

// File: rtl/bootram_if.sv
// PicoRV32 native memory bus as seen by the boot RAM; the CPU side is the master.
interface bootram_if;
    import bootram_pkg::*;

    logic                     mem_valid;
    logic                     mem_ready;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic [BOOTRAM_LANES-1:0] mem_wstrb;
    logic [31:0]              mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/bootram_loader.sv
// Byte-stream loader for the boot RAM: byte pointer, busy flag and ready.
// Only instantiated when BOOTRAM_LOADER_EN is defined.
module bootram_loader
    import bootram_pkg::*;
#(
    parameter int ADDR_W = BOOTRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic              done_i,
    input  logic              idle_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              wr_o,
    output logic [ADDR_W+1:0] ptr_o
);

    logic              busy_q, busy_d;
    logic [ADDR_W+1:0] ptr_q, ptr_d;

    // Start wins over a byte in the same cycle; the last byte of the RAM ends the stream.
    always_comb begin
        ready_o = resetn & busy_q & idle_i & ~start_i;
        wr_o    = valid_i & ready_o;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        if (start_i) begin
            busy_d = 1'b1;
            ptr_d  = '0;
        end else begin
            if (wr_o) begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    busy_d = 1'b0;
                end
            end
            if (done_i) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            ptr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
        end
    end

    assign busy_o = resetn & busy_q;
    assign ptr_o  = ptr_q;

endmodule

// File: rtl/bootram_ctrl.sv
// Boot RAM bus controller: PicoRV32 native bus to four byte-lane BRAMs.
// Define BOOTRAM_LOADER_EN to include the byte-stream loader.
module bootram_ctrl
    import bootram_pkg::*;
#(
    parameter int          ADDR_W    = BOOTRAM_ADDR_W,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     resetn,
    bootram_if.slave                 bus,
    output logic                     ram_ce,
    output logic                     ram_oce,
    output logic                     ram_reset,
    output logic [BOOTRAM_LANES-1:0] ram_wre,
    output logic [ADDR_W-1:0]        ram_ad,
    output logic [31:0]              ram_din,
    input  logic [31:0]              ram_dout,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [7:0]               ld_data,
    input  logic                     ld_done,
    output logic                     ld_ready,
    output logic                     ld_busy
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RDATA = ST_RDATA;
    localparam logic [1:0] ACK   = ST_ACK;

    logic [1:0]        state_q, state_d;
    logic [31:0]       rdata_q;
    logic              hit, accept, cpuRd, cpuWr;
    logic              ldWr, ldBusy;
    logic [ADDR_W+1:0] ldPtr;
    logic              unusedBits;

    assign hit    = bus.mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
    assign accept = resetn & (state_q == IDLE) & bus.mem_valid & hit & ~ldBusy;
    assign cpuRd  = accept & (bus.mem_wstrb == '0);
    assign cpuWr  = accept & (bus.mem_wstrb != '0);

`ifdef BOOTRAM_LOADER_EN
    bootram_loader #(.ADDR_W(ADDR_W)) u_loader (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (ld_start),
        .valid_i (ld_valid),
        .done_i  (ld_done),
        .idle_i  (state_q == IDLE),
        .ready_o (ld_ready),
        .busy_o  (ld_busy),
        .wr_o    (ldWr),
        .ptr_o   (ldPtr)
    );
    assign ldBusy     = ld_busy;
    assign unusedBits = ^bus.mem_addr[1:0];
`else
    assign ld_ready   = 1'b0;
    assign ld_busy    = 1'b0;
    assign ldWr       = 1'b0;
    assign ldPtr      = '0;
    assign ldBusy     = 1'b0;
    assign unusedBits = ^{ld_start, ld_valid, ld_done, bus.mem_addr[1:0]};
`endif

    // CPU and loader strobes never overlap: CPU accepts are blocked while the loader is busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpuRd) state_d = RDATA;
                     else if (cpuWr) state_d = ACK;
            RDATA:   state_d = ACK;
            default: state_d = IDLE;
        endcase

        ram_ce  = cpuRd | cpuWr | ldWr;
        ram_wre = '0;
        ram_ad  = '0;
        ram_din = '0;
        if (accept) begin
            ram_ad = bus.mem_addr[ADDR_W+1:2];
        end
        if (cpuWr) begin
            ram_wre = bus.mem_wstrb;
            ram_din = bus.mem_wdata;
        end else if (ldWr) begin
            ram_wre = BOOTRAM_LANES'(4'b0001 << ldPtr[1:0]);
            ram_ad  = ldPtr[ADDR_W+1:2];
            ram_din = {BOOTRAM_LANES{ld_data}};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RDATA) begin
                rdata_q <= ram_dout;
            end
        end
    end

    assign bus.mem_ready = resetn & (state_q == ACK);
    assign bus.mem_rdata = rdata_q;
    assign ram_oce       = 1'b1;
    assign ram_reset     = ~resetn;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Directed self-checking bench for bootram_ctrl with a behavioural byte-lane BRAM model.
// Loader scenarios are selected by BOOTRAM_LOADER_EN, matching the RTL build.
module tb_bootram_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ram_ce, ram_oce, ram_reset;
    logic [3:0]  ram_wre;
    logic [10:0] ram_ad;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_done = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready, ld_busy;

    int compared = 0;
    int mismatched = 0;

    bootram_if bus();

    bootram_ctrl #(.ADDR_W(11), .BASE_ADDR(32'h0000_0000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset),
        .ram_wre   (ram_wre),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .ld_ready  (ld_ready),
        .ld_busy   (ld_busy)
    );

    always #5 clk = ~clk;

    // Four 2Kx8 lanes, bypass read mode, one-cycle registered read.
    logic [7:0] laneMem [4][2048];

    initial begin
        for (int l = 0; l < 4; l++)
            for (int w = 0; w < 2048; w++)
                laneMem[l][w] = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_reset) begin
            ram_dout <= '0;
        end else if (ram_ce) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_wre[i]) begin
                    laneMem[i][ram_ad] <= ram_din[8*i +: 8];
                    ram_dout[8*i +: 8] <= ram_din[8*i +: 8];
                end else begin
                    ram_dout[8*i +: 8] <= laneMem[i][ram_ad];
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one CPU transfer from an IDLE cycle; captures accept-cycle strobes and ready latency.
    task automatic cpuXfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           output int lat, output logic [31:0] rd, output logic ce0,
                           output logic [3:0] wre0, output logic [10:0] ad0, output logic [31:0] din0);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        #1;
        ce0  = ram_ce;
        wre0 = ram_wre;
        ad0  = ram_ad;
        din0 = ram_din;
        lat  = -1;
        rd   = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) begin
                lat = c;
                rd  = bus.mem_rdata;
                break;
            end
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (bus.mem_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 0", bus.mem_ready); end
        compared++; if (bus.mem_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", bus.mem_rdata); end
        compared++; if (ram_ce !== 1'b0 || ram_wre !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_strobes: ce %b wre %b want 0/0000", ram_ce, ram_wre); end
        compared++; if (ram_oce !== 1'b1 || ram_reset !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ram_ctl: oce %b reset %b want 1/1", ram_oce, ram_reset); end
        compared++; if (ld_busy !== 1'b0 || ld_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_loader: busy %b ready %b want 0/0", ld_busy, ld_ready); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        compared++; if (ram_reset !== 1'b0) begin mismatched++; $display("[TB] FAIL ram_reset_release: got %b want 0", ram_reset); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_full();
        int lat; logic [31:0] rd, din0; logic ce0; logic [3:0] wre0; logic [10:0] ad0;
        cpuXfer(32'h10, 32'hDEADBEEF, 4'hF, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (ce0 !== 1'b1 || wre0 !== 4'hF) begin mismatched++; $display("[TB] FAIL wr_strobes: ce %b wre %b want 1/1111", ce0, wre0); end
        compared++; if (ad0 !== 11'd4) begin mismatched++; $display("[TB] FAIL wr_addr: got %0d want 4", ad0); end
        compared++; if (din0 !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL wr_din: got %h want deadbeef", din0); end
        compared++; if (lat !== 1) begin mismatched++; $display("[TB] FAIL wr_latency: got %0d want 1", lat); end
        compared++; if (bus.mem_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_ready_single: got %b want 0", bus.mem_ready); end
    endtask

    task automatic test_read();
        int lat; logic [31:0] rd, din0; logic ce0; logic [3:0] wre0; logic [10:0] ad0;
        cpuXfer(32'h10, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (ce0 !== 1'b1 || wre0 !== 4'h0 || ad0 !== 11'd4) begin mismatched++; $display("[TB] FAIL rd_strobes: ce %b wre %b ad %0d want 1/0000/4", ce0, wre0, ad0); end
        compared++; if (lat !== 2) begin mismatched++; $display("[TB] FAIL rd_latency: got %0d want 2", lat); end
        compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL rd_data: got %h want deadbeef", rd); end
        compared++; if (bus.mem_rdata !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL rd_hold: got %h want deadbeef", bus.mem_rdata); end
    endtask

    task automatic test_byte_write();
        int lat; logic [31:0] rd, din0; logic ce0; logic [3:0] wre0; logic [10:0] ad0;
        cpuXfer(32'h10, 32'h00AA0000, 4'b0100, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (wre0 !== 4'b0100 || lat !== 1) begin mismatched++; $display("[TB] FAIL byte_wr: wre %b lat %0d want 0100/1", wre0, lat); end
        cpuXfer(32'h10, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (rd !== 32'hDEAABEEF) begin mismatched++; $display("[TB] FAIL byte_readback: got %h want deaabeef", rd); end
    endtask

    task automatic test_miss();
        logic sawActivity = 1'b0;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_2000;
        bus.mem_wstrb = 4'h0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ram_ce !== 1'b0 || bus.mem_ready !== 1'b0) sawActivity = 1'b1;
            @(posedge clk);
        end
        #1;
        bus.mem_valid = 1'b0;
        compared++; if (sawActivity !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_ignored: activity %b want 0", sawActivity); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd, din0; logic ce0; logic [3:0] wre0; logic [10:0] ad0;
        cpuXfer(32'h14, 32'h12345678, 4'hF, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (ce0 !== 1'b1 || lat !== 1) begin mismatched++; $display("[TB] FAIL b2b_wr1: ce %b lat %0d want 1/1", ce0, lat); end
        cpuXfer(32'h18, 32'hCAFEF00D, 4'b0011, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (ce0 !== 1'b1 || lat !== 1 || ad0 !== 11'd6) begin mismatched++; $display("[TB] FAIL b2b_wr2: ce %b lat %0d ad %0d want 1/1/6", ce0, lat, ad0); end
        cpuXfer(32'h14, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (ce0 !== 1'b1 || lat !== 2 || rd !== 32'h12345678) begin mismatched++; $display("[TB] FAIL b2b_rd1: ce %b lat %0d data %h want 1/2/12345678", ce0, lat, rd); end
        cpuXfer(32'h18, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (ce0 !== 1'b1 || lat !== 2 || rd !== 32'h0000F00D) begin mismatched++; $display("[TB] FAIL b2b_rd2: ce %b lat %0d data %h want 1/2/0000f00d", ce0, lat, rd); end
    endtask

    task automatic test_reset_midread();
        int lat; logic [31:0] rd, din0; logic ce0; logic [3:0] wre0; logic [10:0] ad0;
        logic sawReady = 1'b0;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h10;
        bus.mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        if (bus.mem_ready !== 1'b0) sawReady = 1'b1;
        @(posedge clk);
        #1;
        compared++; if (bus.mem_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL midrd_rdata: got %h want 0", bus.mem_rdata); end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready !== 1'b0) sawReady = 1'b1;
        end
        compared++; if (sawReady !== 1'b0) begin mismatched++; $display("[TB] FAIL midrd_no_ready: saw %b want 0", sawReady); end
        cpuXfer(32'h10, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (ce0 !== 1'b1 || lat !== 2 || rd !== 32'hDEAABEEF) begin mismatched++; $display("[TB] FAIL midrd_recover: ce %b lat %0d data %h want 1/2/deaabeef", ce0, lat, rd); end
    endtask

`ifdef BOOTRAM_LOADER_EN
    task automatic test_loader_basic();
        int lat; logic [31:0] rd, din0; logic ce0; logic [3:0] wre0; logic [10:0] ad0;
        logic [7:0] bytes [5] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7};
        logic badByte = 1'b0;
        logic earlyAccept = 1'b0;
        @(negedge clk);
        ld_start = 1'b1;
        #1;
        compared++; if (ld_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL ld_ready_at_start: got %b want 0", ld_ready); end
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        compared++; if (ld_busy !== 1'b1 || ld_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL ld_started: busy %b ready %b want 1/1", ld_busy, ld_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = bytes[i];
            #1;
            if (ram_ce !== 1'b1 || ram_wre !== 4'(1 << (i % 4)) || ram_ad !== 11'(i / 4)) badByte = 1'b1;
            @(posedge clk);
        end
        #1;
        ld_valid = 1'b0;
        compared++; if (badByte !== 1'b0) begin mismatched++; $display("[TB] FAIL ld_byte_strobes: bad %b want 0", badByte); end
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0;
        bus.mem_wstrb = 4'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ram_ce !== 1'b0 || bus.mem_ready !== 1'b0) earlyAccept = 1'b1;
            @(posedge clk);
        end
        compared++; if (earlyAccept !== 1'b0) begin mismatched++; $display("[TB] FAIL ld_cpu_blocked: activity %b want 0", earlyAccept); end
        @(negedge clk);
        ld_done = 1'b1;
        @(posedge clk);
        #1;
        ld_done = 1'b0;
        compared++; if (ld_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ld_done_clears: busy %b want 0", ld_busy); end
        lat = -1;
        rd  = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) begin lat = c; rd = bus.mem_rdata; break; end
        end
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #1;
        compared++; if (lat !== 2 || rd !== 32'h00000013) begin mismatched++; $display("[TB] FAIL ld_word0: lat %0d data %h want 2/00000013", lat, rd); end
        cpuXfer(32'h4, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (rd !== 32'h000000B7) begin mismatched++; $display("[TB] FAIL ld_word1: got %h want 000000b7", rd); end
    endtask

    task automatic test_loader_full();
        int lat; logic [31:0] rd, din0; logic ce0; logic [3:0] wre0; logic [10:0] ad0;
        @(negedge clk);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h55;
        #1;
        compared++; if (ram_ce !== 1'b0) begin mismatched++; $display("[TB] FAIL ld_start_priority: ce %b want 0", ram_ce); end
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        for (int i = 0; i < 8192; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = (i == 0) ? 8'h66 : 8'(i);
            #1;
            if (i == 0) begin
                compared++; if (ram_ad !== 11'd0 || ram_wre !== 4'b0001) begin mismatched++; $display("[TB] FAIL ld_ptr_zero: ad %0d wre %b want 0/0001", ram_ad, ram_wre); end
            end
            if (i == 8191) begin
                compared++; if (ld_busy !== 1'b1 || ram_ad !== 11'd2047 || ram_wre !== 4'b1000) begin mismatched++; $display("[TB] FAIL ld_last_byte: busy %b ad %0d wre %b want 1/2047/1000", ld_busy, ram_ad, ram_wre); end
            end
            @(posedge clk);
        end
        #1;
        compared++; if (ld_busy !== 1'b0 || ld_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL ld_full_end: busy %b ready %b want 0/0", ld_busy, ld_ready); end
        ld_valid = 1'b0;
        cpuXfer(32'h0, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (rd !== 32'h03020166) begin mismatched++; $display("[TB] FAIL ld_full_first: got %h want 03020166", rd); end
        cpuXfer(32'h1FFC, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (rd !== 32'hFFFEFDFC) begin mismatched++; $display("[TB] FAIL ld_full_last: got %h want fffefdfc", rd); end
    endtask
`else
    task automatic test_loader_absent();
        int lat; logic [31:0] rd, din0; logic ce0; logic [3:0] wre0; logic [10:0] ad0;
        @(negedge clk);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h5A;
        #1;
        compared++; if (ld_ready !== 1'b0 || ram_ce !== 1'b0) begin mismatched++; $display("[TB] FAIL noload_start: ready %b ce %b want 0/0", ld_ready, ram_ce); end
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        compared++; if (ld_busy !== 1'b0 || ld_ready !== 1'b0 || ram_ce !== 1'b0) begin mismatched++; $display("[TB] FAIL noload_idle: busy %b ready %b ce %b want 0/0/0", ld_busy, ld_ready, ram_ce); end
        ld_valid = 1'b0;
        cpuXfer(32'h10, 32'h0, 4'h0, lat, rd, ce0, wre0, ad0, din0);
        compared++; if (ce0 !== 1'b1 || lat !== 2 || rd !== 32'hDEAABEEF) begin mismatched++; $display("[TB] FAIL noload_cpu: ce %b lat %0d data %h want 1/2/deaabeef", ce0, lat, rd); end
    endtask
`endif

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        test_reset();
        test_write_full();
        test_read();
        test_byte_write();
        test_miss();
        test_back_to_back();
        test_reset_midread();
`ifdef BOOTRAM_LOADER_EN
        test_loader_basic();
        test_loader_full();
`else
        test_loader_absent();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bootram_ctrl.md
# bootram_ctrl

Bus-side controller for the PicoRV32 boot RAM. It bridges the PicoRV32 native memory interface to four 2K×8 single-port byte-lane BRAM macros (lanes 0..3, each READ_MODE bypass, 1-cycle read). Optionally, it also hosts a byte-stream loader that fills the RAM while the CPU is held off. It sits between the CPU bus decode and the bootram byte-lane instances.

## Interface
- ADDR_W, 11: per-lane word address width; RAM size = 4·2^ADDR_W bytes.
- BASE_ADDR, 32'h0000_0000: base address; hit = mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].

- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- mem_valid  in  1  CPU request valid
- mem_ready  out  1  one-cycle acknowledge pulse
- mem_addr  in  32  byte address; [ADDR_W+1:2] selects the word
- mem_wdata  in  32  write data; lane i = bits [8i+7:8i]
- mem_wstrb  in  4  byte strobes; 0000 = read
- mem_rdata  out  32  registered read data
- ram_ce  out  1  RAM clock enable, shared by all lanes
- ram_oce  out  1  constant 1
- ram_reset  out  1  ~resetn, active-high, to the lane macros
- ram_wre  out  4  per-lane write enable
- ram_ad  out  ADDR_W  word address
- ram_din  out  32  lane write data
- ram_dout  in  32  lane read data; valid the cycle after ce
- ld_start  in  1  loader: start pulse
- ld_valid  in  1  loader: byte valid
- ld_data  in  8  loader: byte
- ld_done  in  1  loader: early end pulse
- ld_ready  out  1  loader: byte accepted when ld_valid & ld_ready
- ld_busy  out  1  loader active; top level holds the CPU in reset

## Operation
- FSM states: IDLE, RDATA, ACK.
- **IDLE, read accept:** mem_valid & hit & wstrb==0 & !ld_busy.
  - ram_ce=1 and ram_ad=mem_addr[ADDR_W+1:2], combinational, in the accept cycle.
  - Next state RDATA.
- **IDLE, write accept:** same condition with wstrb≠0.
  - ram_ce=1, ram_wre=wstrb, ram_din=wdata, in the accept cycle.
  - Next state ACK.
- **RDATA:** mem_rdata <= ram_dout; next state ACK.
- **ACK:** mem_ready=1 for exactly one cycle, then IDLE. No accept occurs in ACK.
- **Misses:** non-hit requests are ignored. No ce, no ready; another slave answers.
- **Unstrobed lanes:** ram_wre bit is 0 and the lane contents are unchanged.
- **Reset:** resetn low at any state → IDLE on the next edge.
  - All outputs 0 except ram_oce=1 and ram_reset=1.
  - An in-flight transaction is dropped with no ready.
- **Combinational RAM strobes:** gated by resetn, so they are 0 during reset.

## Timing
- Write: accept cycle N; mem_ready in N+1.
- Read: accept cycle N; ram_dout valid N+1; mem_ready and mem_rdata valid N+2.
- mem_rdata holds its value until the next read capture.
- Back-to-back: a new accept is possible in the cycle after ACK.
- Throughput: 1 read per 3 cycles, 1 write per 2 cycles.

## Configuration
- BOOTRAM_LOADER_EN defined:
  - ld_start in any state sets byte pointer=0 and ld_busy=1; ld_start has priority over ld_valid in the same cycle.
  - ld_ready = ld_busy & state==IDLE & !ld_start.
  - Each accepted byte writes lane ptr[1:0] at word ptr[ADDR_W+1:2] (ce=1, one wre bit) in the same cycle; ptr increments.
  - ld_busy clears after byte 4·2^ADDR_W−1 or on ld_done.
  - A CPU transaction in flight at ld_start completes first. New CPU requests are not accepted while ld_busy.
- BOOTRAM_LOADER_EN undefined: ld_* inputs are ignored, ld_ready=0, ld_busy=0, and the loader logic is absent. The ports remain.

## Structure
- Package bootram_pkg: FSM state enum, BOOTRAM_LANES=4, default ADDR_W.
- Sub-module bootram_loader: pointer, busy flag and ld_ready. Instantiated only under BOOTRAM_LOADER_EN. The controller muxes loader strobes onto ram_*.

## Test plan
- Write 0xDEADBEEF, wstrb 1111 @0x10 → ce, wre=1111, ad=4 in N; ready N+1. Read @0x10 → ready N+2, rdata=0xDEADBEEF.
- Write 0x00AA0000, wstrb 0100 @0x10 → only wre[2]; readback 0xDEAABEEF.
- Read @0x0000_2000 (BASE 0, ADDR_W 11) → no ce, mem_ready 0 for 8 cycles.
- resetn low during RDATA → next cycle IDLE, mem_ready never pulses, mem_rdata=0, then normal read works.
- Loader: ld_start, then bytes 13,00,00,00,B7 → word0=0x00000013, word1 lane0=0xB7. A CPU read issued while busy is accepted only after ld_done.
- Loader with simultaneous ld_start and ld_valid → byte ignored, ptr=0. Full 8192-byte stream → ld_busy drops after the last byte.
